// File: rtl/exp4_unidade_controle_if.sv
// Control/status bundle between the Exp4 control unit and its surroundings.
interface exp4_unidade_controle_if;
  logic       iniciar;
  logic       jogada;
  logic       chavesIgualMemoria;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  modport master (
    output iniciar, jogada, chavesIgualMemoria, fimC,
    input  zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );

  modport slave (
    input  iniciar, jogada, chavesIgualMemoria, fimC,
    output zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout, db_estado
  );
endinterface

// File: rtl/exp4_unidade_controle.sv
// Moore FSM sequencing one Exp4 play round over the datapath.
// Optional ESPERA timeout enabled by defining TIMEOUT_EN.
module exp4_unidade_controle #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input logic                     clock,
  input logic                     reset,
  exp4_unidade_controle_if.slave  ctl
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARA    = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h4,
    COMPARA    = 4'h5,
    PROXIMO    = 4'h6,
    FIM_ACERTO = 4'hA,
    FIM_TOUT   = 4'hD,
    FIM_ERRO   = 4'hE
  } state_e;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e state_q, state_d;
  logic   jogada_q;
  logic   jpulse;
  logic   tout_hit;

  assign jpulse = ctl.jogada & ~jogada_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= INICIAL;
      jogada_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      jogada_q <= ctl.jogada;
    end
  end

`ifdef TIMEOUT_EN
  logic [TW-1:0] timer_q, timer_d;

  // Counts consecutive ESPERA cycles; any other state restarts the window.
  assign timer_d  = (state_q == ESPERA) ? timer_q + TW'(1) : '0;
  assign tout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end
`else
  logic [TW-1:0] unused_timer;
  assign unused_timer = '0;
  assign tout_hit     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:    if (ctl.iniciar) state_d = PREPARA;
      PREPARA:    state_d = ESPERA;
      ESPERA:     if (jpulse)        state_d = REGISTRA;
                  else if (tout_hit) state_d = FIM_TOUT;
      REGISTRA:   state_d = COMPARA;
      // Mismatch outranks terminal count.
      COMPARA:    if (!ctl.chavesIgualMemoria) state_d = FIM_ERRO;
                  else if (ctl.fimC)           state_d = FIM_ACERTO;
                  else                         state_d = PROXIMO;
      PROXIMO:    state_d = ESPERA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TOUT:   if (ctl.iniciar) state_d = PREPARA;
      default:    state_d = INICIAL;
    endcase
  end

  always_comb begin
    ctl.zeraC     = 1'b0;
    ctl.contaC    = 1'b0;
    ctl.zeraR     = 1'b0;
    ctl.registraR = 1'b0;
    ctl.pronto    = 1'b0;
    ctl.acertou   = 1'b0;
    ctl.errou     = 1'b0;
    ctl.timeout   = 1'b0;
    ctl.db_estado = state_q;
    case (state_q)
      PREPARA:    begin ctl.zeraC = 1'b1; ctl.zeraR = 1'b1; end
      REGISTRA:   ctl.registraR = 1'b1;
      PROXIMO:    ctl.contaC = 1'b1;
      FIM_ACERTO: begin ctl.pronto = 1'b1; ctl.acertou = 1'b1; end
      FIM_ERRO:   begin ctl.pronto = 1'b1; ctl.errou = 1'b1; end
`ifdef TIMEOUT_EN
      FIM_TOUT:   begin ctl.pronto = 1'b1; ctl.timeout = 1'b1; end
`endif
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Scoreboard bench: each step queues the expected post-edge state, then pops and compares.
module tb_exp4_unidade_controle;

`ifdef TIMEOUT_EN
  localparam int TOUT = 8;
`else
  localparam int TOUT = 5000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_conta = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  exp4_unidade_controle_if ifc();

  exp4_unidade_controle #(.TIMEOUT_CYCLES(TOUT)) dut (
    .clock (clk),
    .reset (rst),
    .ctl   (ifc.slave)
  );

  // {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [11:0] outs(input logic [3:0] st);
    logic [7:0] o;
    case (st)
      4'h1:    o = 8'b1010_0000;
      4'h4:    o = 8'b0001_0000;
      4'h6:    o = 8'b0100_0000;
      4'hA:    o = 8'b0000_1100;
      4'hE:    o = 8'b0000_1010;
      4'hD:    o = 8'b0000_1001;
      default: o = 8'b0000_0000;
    endcase
    return {st, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic ini, input logic jog,
                      input logic igual, input logic fim, input logic [3:0] exp_st);
    logic [11:0] e, g;
    rst = r;
    ifc.iniciar = ini;
    ifc.jogada = jog;
    ifc.chavesIgualMemoria = igual;
    ifc.fimC = fim;
    exp_q.push_back(outs(exp_st));
    @(posedge clk);
    #1;
    g = {ifc.db_estado, ifc.zeraC, ifc.contaC, ifc.zeraR, ifc.registraR,
         ifc.pronto, ifc.acertou, ifc.errou, ifc.timeout};
    if (ifc.contaC === 1'b1) n_conta++;
    e = exp_q.pop_front();
    chk(tag, {20'd0, g}, {20'd0, e});
  endtask

  initial begin
    ifc.iniciar = 1'b0;
    ifc.jogada = 1'b0;
    ifc.chavesIgualMemoria = 1'b0;
    ifc.fimC = 1'b0;

    // reset and start
    step("rst0",     1, 0, 0, 0, 0, 4'h0);
    step("rst1",     1, 1, 0, 0, 0, 4'h0);
    step("idle",     0, 0, 0, 0, 0, 4'h0);
    step("start",    0, 1, 0, 0, 0, 4'h1);
    step("prep",     0, 1, 0, 0, 0, 4'h2);
    step("ini_ign",  0, 1, 0, 0, 0, 4'h2);
    step("wait",     0, 0, 0, 0, 0, 4'h2);
    // play 1, then key held high
    step("p1_reg",   0, 0, 1, 1, 0, 4'h4);
    step("p1_cmp",   0, 0, 1, 1, 0, 4'h5);
    step("p1_next",  0, 0, 1, 1, 0, 4'h6);
    step("p1_back",  0, 0, 1, 1, 0, 4'h2);
    step("held0",    0, 0, 1, 1, 0, 4'h2);
    step("held1",    0, 0, 1, 1, 0, 4'h2);
    step("release",  0, 0, 0, 1, 0, 4'h2);
    // play 2
    step("p2_reg",   0, 0, 1, 1, 0, 4'h4);
    step("p2_cmp",   0, 0, 0, 1, 0, 4'h5);
    step("p2_next",  0, 0, 0, 1, 0, 4'h6);
    step("p2_back",  0, 0, 0, 1, 0, 4'h2);
    // play 3 reaches terminal count
    step("p3_reg",   0, 0, 1, 1, 1, 4'h4);
    step("p3_cmp",   0, 0, 0, 1, 1, 4'h5);
    step("p3_win",   0, 0, 0, 1, 1, 4'hA);
    step("win_hold", 0, 0, 1, 0, 0, 4'hA);
    step("win_hld2", 0, 0, 0, 0, 0, 4'hA);
    chk("conta_cnt", n_conta, 2);
    // restart, then a mismatch that also has fimC high
    step("restart",  0, 1, 0, 0, 0, 4'h1);
    step("r_wait",   0, 0, 0, 0, 0, 4'h2);
    step("e_reg",    0, 0, 1, 0, 1, 4'h4);
    step("e_cmp",    0, 0, 0, 0, 1, 4'h5);
    step("e_err",    0, 0, 0, 0, 1, 4'hE);
    step("err_hold", 0, 0, 0, 1, 0, 4'hE);
    step("err_rst",  0, 1, 0, 0, 0, 4'h1);
    step("er_wait",  0, 0, 0, 0, 0, 4'h2);
    // mismatch on a non-terminal position
    step("m_reg",    0, 0, 1, 0, 0, 4'h4);
    step("m_cmp",    0, 0, 1, 0, 0, 4'h5);
    step("m_err",    0, 0, 1, 0, 0, 4'hE);
    step("m_start",  0, 1, 0, 0, 0, 4'h1);
    step("m_wait",   0, 0, 0, 0, 0, 4'h2);
    // reset while in COMPARA
    step("c_reg",    0, 0, 1, 1, 0, 4'h4);
    step("c_cmp",    0, 0, 0, 1, 0, 4'h5);
    step("c_rst",    1, 0, 0, 1, 0, 4'h0);
    step("c_idle",   0, 0, 0, 1, 0, 4'h0);
`ifdef TIMEOUT_EN
    step("t_start",  0, 1, 0, 1, 0, 4'h1);
    step("t_esp",    0, 0, 0, 1, 0, 4'h2);
    for (int i = 0; i < TOUT - 1; i++) step("t_wait", 0, 0, 0, 1, 0, 4'h2);
    step("t_tout",   0, 0, 0, 1, 0, 4'hD);
    step("t_hold",   0, 0, 0, 1, 0, 4'hD);
    step("t_again",  0, 1, 0, 1, 0, 4'h1);
    step("t_esp2",   0, 0, 0, 1, 0, 4'h2);
    for (int i = 0; i < TOUT - 1; i++) step("t_wait2", 0, 0, 0, 1, 0, 4'h2);
    step("t_jwin",   0, 0, 1, 1, 0, 4'h4);
`endif
    chk("q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
